// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a synchronous instruction memory, sequences the PC,
// absorbs decode stalls with a one-entry skid buffer and squashes fetches on redirect.
module instr_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] Iaddress,
    input  logic [XLEN-1:0] Idata,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out
);

    typedef enum logic {
        FETCH = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic              hold_valid_q, hold_valid_d;

    logic [XLEN-1:0]   target_pc;
    logic [XLEN-1:0]   seq_pc;
    logic              sel_valid;
    logic [XLEN-1:0]   sel_instr;
    logic [XLEN-1:0]   sel_pc;
    logic              unused_redirect_lsbs;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign target_pc            = {redirect_pc[XLEN-1:2], 2'b00};
    assign seq_pc               = fetch_pc_q + XLEN'(4);
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign Iaddress             = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (stall)  state_d = STALL;
                STALL:   if (!stall) state_d = FETCH;
                default:             state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;
        if (redirect) begin
            // Squash the read in flight and any parked entry.
            fetch_pc_d   = target_pc;
            req_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
        end else if (state_q == FETCH) begin
            if (stall) begin
                // Park the presented entry; the memory re-reads fetch_pc meanwhile.
                hold_instr_d = Idata;
                hold_pc_d    = req_pc_q;
                hold_valid_d = req_valid_q;
                req_pc_d     = fetch_pc_q;
                req_valid_d  = 1'b1;
            end else begin
                fetch_pc_d  = seq_pc;
                req_pc_d    = fetch_pc_q;
                req_valid_d = 1'b1;
            end
        end else if (!stall) begin
            fetch_pc_d  = seq_pc;
            req_pc_d    = fetch_pc_q;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            req_valid_q  <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= RESET_PC;
            hold_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        sel_valid = req_valid_q;
        sel_instr = Idata;
        sel_pc    = req_pc_q;
        if (state_q == STALL) begin
            sel_valid = hold_valid_q;
            sel_instr = hold_instr_q;
            sel_pc    = hold_pc_q;
        end
        valid_out = sel_valid;
        instr_out = sel_valid ? sel_instr : NOP_INSTR;
        pc_out    = sel_pc;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, redirect, reset and PC wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        n_reset_a, stall_a, redirect_a;
    logic [31:0] redirect_pc_a, Iaddress_a, Idata_a, instr_a, pc_a;
    logic        valid_a;

    logic        n_reset_b, stall_b, redirect_b;
    logic [31:0] redirect_pc_b, Iaddress_b, Idata_b, instr_b, pc_b;
    logic        valid_b;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut_a (
        .clk(clk), .n_reset(n_reset_a), .stall(stall_a), .redirect(redirect_a),
        .redirect_pc(redirect_pc_a), .Iaddress(Iaddress_a), .Idata(Idata_a),
        .instr_out(instr_a), .pc_out(pc_a), .valid_out(valid_a)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) dut_b (
        .clk(clk), .n_reset(n_reset_b), .stall(stall_b), .redirect(redirect_b),
        .redirect_pc(redirect_pc_b), .Iaddress(Iaddress_b), .Idata(Idata_b),
        .instr_out(instr_b), .pc_out(pc_b), .valid_out(valid_b)
    );

    // Synchronous memory model: mem[k] = 0x10000000 + k, one cycle read latency.
    always @(posedge clk) begin
        Idata_a <= 32'h1000_0000 + {2'b00, Iaddress_a[31:2]};
        Idata_b <= 32'h1000_0000 + {2'b00, Iaddress_b[31:2]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset_a = 1'b0; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = '0;
        n_reset_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;
        tick(); tick();
        n_reset_a = 1'b1;
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b0, 32'h0, 32'h0000_0013}) begin
            errors++;
            $display("FAIL reset_out: got v=%b pc=%h instr=%h, need v=0 pc=00000000 instr=00000013", valid_a, pc_a, instr_a);
        end
        checks++;
        if (Iaddress_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_iaddr: got %h, need 00000000", Iaddress_a);
        end
        $display("reset: v=%b pc=%h instr=%h iaddr=%h", valid_a, pc_a, instr_a, Iaddress_a);
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] exp_in [4] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({valid_a, pc_a, instr_a} !== {1'b1, exp_pc[i], exp_in[i]}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h, need v=1 pc=%h instr=%h", i, valid_a, pc_a, instr_a, exp_pc[i], exp_in[i]);
            end
            $display("stream: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
        end
    endtask

    task automatic test_stall();
        // Stall is high for the three cycles presenting pc 8; pc 8 transfers on the fourth.
        tick();
        for (int i = 0; i < 4; i++) begin
            stall_a = (i < 3);
            checks++;
            if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h8, 32'h1000_0002}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h, need v=1 pc=00000008 instr=10000002", i, valid_a, pc_a, instr_a);
            end
            $display("stall: cyc=%0d stall=%b v=%b pc=%h instr=%h iaddr=%h", i, stall_a, valid_a, pc_a, instr_a, Iaddress_a);
            if (i > 0) begin
                checks++;
                if (Iaddress_a !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_iaddr_%0d: got %h, need 0000000c", i, Iaddress_a);
                end
            end
            if (i < 3) tick();
        end
        stall_a = 1'b0;
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'hC, 32'h1000_0003}) begin
            errors++;
            $display("FAIL stall_release_12: got v=%b pc=%h instr=%h, need v=1 pc=0000000c instr=10000003", valid_a, pc_a, instr_a);
        end
        $display("release: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h10, 32'h1000_0004}) begin
            errors++;
            $display("FAIL stall_release_16: got v=%b pc=%h instr=%h, need v=1 pc=00000010 instr=10000004", valid_a, pc_a, instr_a);
        end
        $display("release: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
    endtask

    task automatic test_redirect();
        redirect_a = 1'b1; redirect_pc_a = 32'h40;
        tick();
        redirect_a = 1'b0;
        checks++;
        if ({valid_a, instr_a, Iaddress_a} !== {1'b0, 32'h0000_0013, 32'h40}) begin
            errors++;
            $display("FAIL redirect_bubble: got v=%b instr=%h iaddr=%h, need v=0 instr=00000013 iaddr=00000040", valid_a, instr_a, Iaddress_a);
        end
        $display("redirect: bubble v=%b instr=%h iaddr=%h", valid_a, instr_a, Iaddress_a);
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h40, 32'h1000_0010}) begin
            errors++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h, need v=1 pc=00000040 instr=10000010", valid_a, pc_a, instr_a);
        end
        $display("redirect: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h44, 32'h1000_0011}) begin
            errors++;
            $display("FAIL redirect_next: got v=%b pc=%h instr=%h, need v=1 pc=00000044 instr=10000011", valid_a, pc_a, instr_a);
        end
    endtask

    task automatic test_redirect_stall();
        redirect_a = 1'b1; stall_a = 1'b1; redirect_pc_a = 32'h23;
        tick();
        redirect_a = 1'b0; stall_a = 1'b0;
        checks++;
        if ({valid_a, Iaddress_a} !== {1'b0, 32'h20}) begin
            errors++;
            $display("FAIL redir_stall_bubble: got v=%b iaddr=%h, need v=0 iaddr=00000020", valid_a, Iaddress_a);
        end
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h20, 32'h1000_0008}) begin
            errors++;
            $display("FAIL redir_stall_target: got v=%b pc=%h instr=%h, need v=1 pc=00000020 instr=10000008", valid_a, pc_a, instr_a);
        end
        $display("redirect+stall: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
    endtask

    task automatic test_back_to_back();
        redirect_a = 1'b1; redirect_pc_a = 32'h100;
        tick();
        redirect_pc_a = 32'h200;
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble1: got v=%b, need v=0", valid_a);
        end
        tick();
        redirect_a = 1'b0;
        checks++;
        if ({valid_a, Iaddress_a} !== {1'b0, 32'h200}) begin
            errors++;
            $display("FAIL b2b_bubble2: got v=%b iaddr=%h, need v=0 iaddr=00000200", valid_a, Iaddress_a);
        end
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h200, 32'h1000_0080}) begin
            errors++;
            $display("FAIL b2b_target: got v=%b pc=%h instr=%h, need v=1 pc=00000200 instr=10000080", valid_a, pc_a, instr_a);
        end
        $display("back_to_back: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
    endtask

    task automatic test_stall_bubble();
        redirect_a = 1'b1; redirect_pc_a = 32'h80;
        tick();
        redirect_a = 1'b0; stall_a = 1'b1;
        tick();
        stall_a = 1'b0;
        checks++;
        if ({valid_a, instr_a} !== {1'b0, 32'h0000_0013}) begin
            errors++;
            $display("FAIL stall_bubble_hold: got v=%b instr=%h, need v=0 instr=00000013", valid_a, instr_a);
        end
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h80, 32'h1000_0020}) begin
            errors++;
            $display("FAIL stall_bubble_after: got v=%b pc=%h instr=%h, need v=1 pc=00000080 instr=10000020", valid_a, pc_a, instr_a);
        end
        $display("stall_bubble: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
    endtask

    task automatic test_reset_mid_stall();
        redirect_a = 1'b1; redirect_pc_a = 32'h10;
        tick();
        redirect_a = 1'b0;
        tick();
        stall_a = 1'b1;
        checks++;
        if ({valid_a, pc_a} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL rst_stall_pre: got v=%b pc=%h, need v=1 pc=00000010", valid_a, pc_a);
        end
        tick();
        n_reset_a = 1'b0;
        tick();
        n_reset_a = 1'b1; stall_a = 1'b0;
        checks++;
        if ({valid_a, pc_a, instr_a, Iaddress_a} !== {1'b0, 32'h0, 32'h0000_0013, 32'h0}) begin
            errors++;
            $display("FAIL rst_stall_out: got v=%b pc=%h instr=%h iaddr=%h, need v=0 pc=0 instr=00000013 iaddr=0", valid_a, pc_a, instr_a, Iaddress_a);
        end
        tick();
        checks++;
        if ({valid_a, pc_a, instr_a} !== {1'b1, 32'h0, 32'h1000_0000}) begin
            errors++;
            $display("FAIL rst_stall_restart: got v=%b pc=%h instr=%h, need v=1 pc=00000000 instr=10000000", valid_a, pc_a, instr_a);
        end
        $display("reset_mid_stall: v=%b pc=%h instr=%h", valid_a, pc_a, instr_a);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] exp_in [3] = '{32'h4FFF_FFFE, 32'h4FFF_FFFF, 32'h1000_0000};
        n_reset_b = 1'b0;
        tick();
        n_reset_b = 1'b1;
        checks++;
        if ({valid_b, pc_b, Iaddress_b} !== {1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8}) begin
            errors++;
            $display("FAIL wrap_reset: got v=%b pc=%h iaddr=%h, need v=0 pc=fffffff8 iaddr=fffffff8", valid_b, pc_b, Iaddress_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_b, pc_b, instr_b} !== {1'b1, exp_pc[i], exp_in[i]}) begin
                errors++;
                $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h, need v=1 pc=%h instr=%h", i, valid_b, pc_b, instr_b, exp_pc[i], exp_in[i]);
            end
            $display("wrap: v=%b pc=%h instr=%h", valid_b, pc_b, instr_b);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_back_to_back();
        test_stall_bubble();
        test_reset_mid_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit for the 32-bit RISC-V core; the initiator side of the instruction memory interface. Drives Iaddress to the synchronous instruction memory and receives Idata one cycle later. Maintains the PC, sequences addresses by +4, and absorbs decode-stage stalls with a one-entry skid buffer. Handles control-flow redirects by squashing in-flight fetches, then presents (instr, pc, valid) to decode.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, instruction driven when valid_out=0 (ADDI x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on posedge
n_reset  input  1  reset; synchronous, active-low
stall  input  1  decode cannot accept; hold current output
redirect  input  1  branch/jump taken; restart fetch at redirect_pc
redirect_pc  input  XLEN  target address; bits [1:0] ignored (forced 0)
Iaddress  output  XLEN  address to instruction memory (register output, no combinational path from inputs)
Idata  input  XLEN  memory read data; equals mem[Iaddress sampled at previous posedge]
instr_out  output  XLEN  instruction to decode
pc_out  output  XLEN  PC of instr_out
valid_out  output  1  instr_out/pc_out valid; transfer occurs when valid_out=1 and stall=0

Behaviour:
- Registers: fetch_pc (drives Iaddress), req_pc_q/req_valid_q (address and validity of the read in flight), hold_instr/hold_pc/hold_valid (skid buffer), state in {FETCH, STALL}.
- Output mux: state STALL -> hold_* registers; state FETCH -> Idata, req_pc_q, req_valid_q. When the selected valid is 0, instr_out=NOP_INSTR.
- Reset (n_reset=0 at posedge, overrides everything, including mid-stall and mid-redirect): fetch_pc<=RESET_PC, req_valid_q<=0, req_pc_q<=RESET_PC, hold_valid<=0, state<=FETCH. After reset: valid_out=0, instr_out=NOP_INSTR, pc_out=RESET_PC, Iaddress=RESET_PC. First valid output appears 1 cycle after reset release.
- Priority per edge: n_reset > redirect > stall > normal.
- FETCH, no stall: fetch_pc<=fetch_pc+4, req_pc_q<=fetch_pc, req_valid_q<=1. Steady state is 1 instruction per cycle.
- FETCH, stall=1: capture the current outputs (Idata, req_pc_q, req_valid_q) into hold_*. Set req_pc_q<=fetch_pc, req_valid_q<=1. fetch_pc holds. state<=STALL.
- STALL, stall=1: all registers hold. Outputs stay stable from hold_*. Memory keeps re-reading fetch_pc.
- STALL, stall=0: the hold entry transfers this cycle. fetch_pc<=fetch_pc+4, req_pc_q<=fetch_pc, req_valid_q<=1, state<=FETCH. The next output is mem[fetch_pc], so no instruction is lost or duplicated.
- redirect=1 (any state, regardless of stall): fetch_pc<={redirect_pc[XLEN-1:2],2'b00}, req_valid_q<=0, hold_valid<=0, state<=FETCH. The current-cycle output is still presented, but the redirecting stage discards it.
  - Next cycle: valid_out=0 (one bubble), Iaddress=target.
  - Cycle after: instr_out=mem[target], pc_out=target, valid_out=1.
- Redirect on consecutive cycles: the last one wins; bubbles continue until 1 cycle after the final redirect.
- Arithmetic: fetch_pc+4 is modulo 2^XLEN (0xFFFFFFFC -> 0x00000000), with no flag. Iaddress[1:0] is always 00.
- stall while valid_out=0: freezes as normal; hold_valid=0 is captured, and no invalid instruction is ever reported valid.

Test Plan:
- Memory preloaded with mem[k]=0x10000000+k. Release reset with RESET_PC=0 -> cycle 1: valid_out=0, Iaddress=0. Then pc_out=0,4,8,12 with instr_out=0x10000000..0x10000003 on consecutive cycles.
- Assert stall for 3 cycles while pc_out=8 -> instr_out=0x10000002/pc_out=8 held stable for all 3 cycles. On release, the next outputs are pc 12, 16 with no gap and no duplicate.
- redirect=1, redirect_pc=0x40 while streaming -> next cycle valid_out=0 and instr_out=0x00000013. Following cycle pc_out=0x40, instr_out=0x10000010.
- redirect and stall asserted together with redirect_pc=0x23 -> redirect wins, target is aligned to 0x20, the stall entry is dropped, and the first valid output is pc_out=0x20.
- n_reset=0 during a 2-cycle stall at pc 0x10 -> next cycle valid_out=0, pc_out=RESET_PC, state FETCH. Fetch restarts at 0.
- RESET_PC=0xFFFFFFF8 -> pc_out sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap), all with valid_out=1.
